// File: rtl/vec_op_sequencer.sv
// Control sequencer for the vector CFU datapath: decodes one command, steps it across the LMUL
// register group, and returns a 32-bit response. Optional busy-cycle counter: VEC_SEQ_PERF_CNT_EN.
module vec_op_sequencer #(
  parameter int NUM_REGS      = 32,
  parameter int MAX_LMUL_LOG2 = 3,
  parameter int VLEN_W        = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_payload_function_id,
  input  logic [31:0]       cmd_payload_inputs_0,
  input  logic [31:0]       cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_payload_outputs_0,
  output logic [4:0]        reg_op0_sel,
  output logic [4:0]        reg_op1_sel,
  output logic [4:0]        reg_wb_sel,
  output logic              reg_load,
  output logic [1:0]        bus_sel,
  output logic [1:0]        alu_mode,
  output logic              alu_op1_sel,
  output logic [7:0]        alu_imm,
  output logic [2:0]        vlmul,
  output logic [VLEN_W-1:0] vlen
);

  localparam int IDX_W = MAX_LMUL_LOG2;

  localparam logic [2:0] F_SETVL   = 3'd0;
  localparam logic [2:0] F_VADD_VV = 3'd1;
  localparam logic [2:0] F_VSUB_VV = 3'd2;
  localparam logic [2:0] F_VADD_VI = 3'd3;
  localparam logic [2:0] F_VMUL_VV = 3'd4;
  localparam logic [2:0] F_VACC    = 3'd5;
  localparam logic [2:0] F_PERF    = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        f3_q;
  logic [4:0]        vs1_q, vs2_q, vd_q;
  logic [7:0]        imm_q;
  logic [IDX_W-1:0]  idx_q, last_q, grp_last;
  logic [2:0]        vlmul_q;
  logic [VLEN_W-1:0] vlen_q;
  logic [31:0]       rsp_q;
  logic [2:0]        cmd_f3;
  logic              accept;
  logic              cmd_is_exec;

  // Both channels use plain valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; the offering side holds its payload steady until that edge.
  assign cmd_ready   = (state_q == IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign cmd_f3      = cmd_payload_function_id[2:0];
  assign cmd_is_exec = (cmd_f3 >= F_VADD_VV) && (cmd_f3 <= F_VACC);

  assign rsp_valid             = (state_q == RESP);
  assign rsp_payload_outputs_0 = rsp_q;
  assign vlmul                 = vlmul_q;
  assign vlen                  = vlen_q;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_0[23:21],
                             cmd_payload_inputs_0[15:13], cmd_payload_inputs_0[7:5],
                             cmd_payload_inputs_1[31:VLEN_W]};

  function automatic logic [4:0] wrap_idx(input logic [4:0] base, input logic [IDX_W-1:0] off);
    return 5'((int'(base) + int'(off)) % NUM_REGS);
  endfunction

  // Last group index (N-1); reserved vlmul codes and VACC collapse to a single register.
  always_comb begin
    grp_last = '0;
    if (cmd_f3 != F_VACC && !vlmul_q[2])
      grp_last = IDX_W'((1 << vlmul_q[1:0]) - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    reg_op0_sel = '0;
    reg_op1_sel = '0;
    reg_wb_sel  = '0;
    reg_load    = 1'b0;
    bus_sel     = 2'b00;
    alu_mode    = 2'b00;
    alu_op1_sel = 1'b0;
    alu_imm     = '0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = cmd_is_exec ? EXEC : RESP;
      end
      EXEC: begin
        reg_op0_sel = wrap_idx(vs1_q, idx_q);
        reg_op1_sel = wrap_idx(vs2_q, idx_q);
        reg_wb_sel  = wrap_idx(vd_q, idx_q);
        reg_load    = 1'b1;
        case (f3_q)
          F_VADD_VV: bus_sel = 2'b01;
          F_VSUB_VV: begin
            bus_sel  = 2'b01;
            alu_mode = 2'b01;
          end
          F_VADD_VI: begin
            bus_sel     = 2'b01;
            alu_op1_sel = 1'b1;
            alu_imm     = imm_q;
          end
          F_VMUL_VV: bus_sel = 2'b10;
          F_VACC:    bus_sel = 2'b11;
          default:   bus_sel = 2'b00;
        endcase
        if (idx_q == last_q) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef VEC_SEQ_PERF_CNT_EN
  logic [31:0] busy_q;

  always_ff @(posedge clk) begin
    if (reset)                          busy_q <= '0;
    else if (accept && cmd_f3 == F_PERF) busy_q <= '0;
    else if (state_q == EXEC)           busy_q <= busy_q + 32'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      imm_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      vlmul_q <= '0;
      vlen_q  <= '0;
      rsp_q   <= '0;
    end else begin
      if (accept) begin
        f3_q   <= cmd_f3;
        vs1_q  <= cmd_payload_inputs_0[4:0];
        vs2_q  <= cmd_payload_inputs_0[12:8];
        vd_q   <= cmd_payload_inputs_0[20:16];
        imm_q  <= cmd_payload_inputs_0[31:24];
        idx_q  <= '0;
        last_q <= grp_last;
        // The response is fixed at accept time, so it is already stable when RESP is entered.
        if (cmd_f3 == F_SETVL) begin
          vlmul_q <= cmd_payload_inputs_0[2:0];
          vlen_q  <= cmd_payload_inputs_1[VLEN_W-1:0];
          rsp_q   <= 32'(cmd_payload_inputs_1[VLEN_W-1:0]);
        end else if (cmd_is_exec) begin
          rsp_q <= 32'(grp_last) + 32'd1;
`ifdef VEC_SEQ_PERF_CNT_EN
        end else if (cmd_f3 == F_PERF) begin
          rsp_q <= busy_q;
`endif
        end else begin
          rsp_q <= 32'hFFFF_FFFF;
        end
      end else if (state_q == EXEC) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Self-checking bench for vec_op_sequencer: directed vector table, hand-written corner sequences
// and randomized commands checked against a behavioural group/response model.
module tb_vec_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id = '0;
  logic [31:0] cmd_payload_inputs_0 = '0;
  logic [31:0] cmd_payload_inputs_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_payload_outputs_0;
  logic [4:0]  reg_op0_sel, reg_op1_sel, reg_wb_sel;
  logic        reg_load;
  logic [1:0]  bus_sel, alu_mode;
  logic        alu_op1_sel;
  logic [7:0]  alu_imm;
  logic [2:0]  vlmul;
  logic [5:0]  vlen;

  vec_op_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .reg_op0_sel(reg_op0_sel), .reg_op1_sel(reg_op1_sel), .reg_wb_sel(reg_wb_sel),
    .reg_load(reg_load), .bus_sel(bus_sel), .alu_mode(alu_mode),
    .alu_op1_sel(alu_op1_sel), .alu_imm(alu_imm), .vlmul(vlmul), .vlen(vlen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected write records: {op0, op1, wb, bus_sel, alu_mode, alu_op1_sel, alu_imm}
  logic [27:0] exp_q[$];

  int          m_vlmul = 0;
  int          m_vlen = 0;
  logic [31:0] m_busy = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: group size from the configuration rules, one write record per register.
  task automatic model_cmd(input logic [2:0] f3, input logic [31:0] in0, input logic [31:0] in1,
                           output int n, output logic [31:0] rsp);
    logic [1:0] bus;
    n = 0;
    rsp = 32'hFFFF_FFFF;
    if (f3 == 3'd0) begin
      m_vlmul = int'(in0[2:0]);
      m_vlen  = int'(in1[5:0]);
      rsp     = 32'(in1[5:0]);
    end else if (f3 >= 3'd1 && f3 <= 3'd5) begin
      if (f3 == 3'd5 || m_vlmul > 3) n = 1;
      else n = 2 ** m_vlmul;
      bus = (f3 == 3'd4) ? 2'b10 : (f3 == 3'd5) ? 2'b11 : 2'b01;
      for (int i = 0; i < n; i++)
        exp_q.push_back({5'((int'(in0[4:0]) + i) % 32), 5'((int'(in0[12:8]) + i) % 32),
                         5'((int'(in0[20:16]) + i) % 32), bus,
                         (f3 == 3'd2) ? 2'b01 : 2'b00, (f3 == 3'd3),
                         (f3 == 3'd3) ? in0[31:24] : 8'h00});
      rsp = 32'(n);
      m_busy = m_busy + 32'(n);
    end else if (f3 == 3'd7) begin
`ifdef VEC_SEQ_PERF_CNT_EN
      rsp = m_busy;
      m_busy = '0;
`endif
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_vlmul = 0;
    m_vlen = 0;
    m_busy = '0;
    exp_q.delete();
  endtask

  // Issue one command, check every EXEC cycle and the response. With stall > 0, rsp_ready is held
  // low for that many cycles while a competing command is offered.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] in0, input logic [31:0] in1,
                        input bit use_tbl, input logic [31:0] tbl_rsp, input int stall);
    int n;
    int cyc;
    bit done;
    logic [31:0] mrsp, exp_rsp;
    model_cmd(f3, in0, in1, n, mrsp);
    exp_rsp = use_tbl ? tbl_rsp : mrsp;
    @(negedge clk);
    cmd_payload_function_id = {7'h55, f3};
    cmd_payload_inputs_0 = in0;
    cmd_payload_inputs_1 = in1;
    cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    done = 0;
    while (!done && cyc <= 40) begin
      if (reg_load) begin
        if (exp_q.size() == 0) chk("extra_write", 32'd1, 32'd0);
        else chk("write", 32'({reg_op0_sel, reg_op1_sel, reg_wb_sel, bus_sel, alu_mode,
                               alu_op1_sel, alu_imm}), 32'(exp_q.pop_front()));
      end else begin
        chk("bus_off", 32'(bus_sel), 32'd0);
      end
      if (rsp_valid) begin
        chk("latency", 32'(cyc), (f3 >= 3'd1 && f3 <= 3'd5) ? 32'(n + 1) : 32'd1);
        chk("rsp_data", rsp_payload_outputs_0, exp_rsp);
        if (stall > 0) begin
          cmd_payload_function_id = 10'd1;
          cmd_valid = 1'b1;
          for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", rsp_payload_outputs_0, exp_rsp);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("stall_load", 32'(reg_load), 32'd0);
          end
          cmd_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
        done = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("vlmul", 32'(vlmul), 32'(m_vlmul));
    chk("vlen", 32'(vlen), 32'(m_vlen));
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] rsp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{3'd0, 32'd2,          32'd40,         32'd40};
    tbl[1]  = '{3'd1, 32'h000C_0804,  32'h0,          32'd4};
    tbl[2]  = '{3'd2, 32'h0002_0100,  32'h0,          32'd4};
    tbl[3]  = '{3'd0, 32'd3,          32'd5,          32'd5};
    tbl[4]  = '{3'd4, 32'h001E_001C,  32'h0,          32'd8};
    tbl[5]  = '{3'd3, 32'h5511_031F,  32'h0,          32'd8};
    tbl[6]  = '{3'd5, 32'h0005_0403,  32'h0,          32'd1};
    tbl[7]  = '{3'd6, 32'h0001_0101,  32'h0,          32'hFFFF_FFFF};
    tbl[8]  = '{3'd0, 32'd5,          32'hFFFF_FFFF,  32'd63};
    tbl[9]  = '{3'd1, 32'h0009_0807,  32'h0,          32'd1};
    tbl[10] = '{3'd0, 32'd1,          32'd7,          32'd7};
    tbl[11] = '{3'd4, 32'h001F_1F1F,  32'h0,          32'd2};

    apply_reset();
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_payload_outputs_0, 32'd0);
    chk("rst_reg_load", 32'(reg_load), 32'd0);
    chk("rst_sels", 32'({reg_op0_sel, reg_op1_sel, reg_wb_sel}), 32'd0);
    chk("rst_ctrl", 32'({bus_sel, alu_mode, alu_op1_sel, alu_imm}), 32'd0);
    chk("rst_vlmul", 32'(vlmul), 32'd0);
    chk("rst_vlen", 32'(vlen), 32'd0);

    foreach (tbl[i]) run_op(tbl[i].f3, tbl[i].in0, tbl[i].in1, 1'b1, tbl[i].rsp, 0);

    // Stalled response with a competing command held pending.
    run_op(3'd0, 32'd3, 32'd9, 1'b1, 32'd9, 0);
    run_op(3'd5, 32'h0003_0201, 32'h0, 1'b1, 32'd1, 5);

    // Reset on the second EXEC cycle of a four-register VADD.VI.
    run_op(3'd0, 32'd2, 32'd12, 1'b1, 32'd12, 0);
    @(negedge clk);
    cmd_payload_function_id = 10'd3;
    cmd_payload_inputs_0 = 32'h7F03_0201;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("vi_load0", 32'(reg_load), 32'd1);
    chk("vi_wb0", 32'(reg_wb_sel), 32'd3);
    @(negedge clk);
    chk("vi_imm1", 32'({alu_op1_sel, alu_imm}), 32'h17F);
    chk("vi_wb1", 32'(reg_wb_sel), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_load", 32'(reg_load), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_vlmul", 32'(vlmul), 32'd0);
    reset = 1'b0;
    m_vlmul = 0;
    m_vlen = 0;
    m_busy = '0;

`ifdef VEC_SEQ_PERF_CNT_EN
    run_op(3'd0, 32'd2, 32'd0, 1'b1, 32'd0, 0);
    run_op(3'd1, 32'h0000_0000, 32'h0, 1'b1, 32'd4, 0);
    run_op(3'd0, 32'd1, 32'd0, 1'b1, 32'd0, 0);
    run_op(3'd2, 32'h0001_0101, 32'h0, 1'b1, 32'd2, 0);
    run_op(3'd7, 32'h0, 32'h0, 1'b1, 32'd6, 0);
    run_op(3'd7, 32'h0, 32'h0, 1'b1, 32'd0, 0);
`else
    run_op(3'd7, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 0);
`endif

    for (int r = 0; r < 40; r++)
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0, 32'h0, int'($urandom_range(0, 2)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
